// File: rtl/muldiv_seq_pkg.sv
// Shared RV32M mul/div definitions: funct3 op encodings, FSM states, operand-class helpers.
// Define MULDIV_EARLY_OUT_EN at build time to let zero/overflow cases bypass the iterative CALC phase.
package muldiv_seq_pkg;

    localparam logic [2:0] MD_MUL    = 3'b000;
    localparam logic [2:0] MD_MULH   = 3'b001;
    localparam logic [2:0] MD_MULHSU = 3'b010;
    localparam logic [2:0] MD_MULHU  = 3'b011;
    localparam logic [2:0] MD_DIV    = 3'b100;
    localparam logic [2:0] MD_DIVU   = 3'b101;
    localparam logic [2:0] MD_REM    = 3'b110;
    localparam logic [2:0] MD_REMU   = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    function automatic logic op_is_div(input logic [2:0] op);
        return op[2];
    endfunction

    function automatic logic op_signed1(input logic [2:0] op);
        return (op == MD_MULH) || (op == MD_MULHSU) || (op == MD_DIV) || (op == MD_REM);
    endfunction

    function automatic logic op_signed2(input logic [2:0] op);
        return (op == MD_MULH) || (op == MD_DIV) || (op == MD_REM);
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration: shift-add multiply or restoring shift-subtract divide on a {hi, lo} register.
// Purely combinational; divide keeps remainder in hi and grows the quotient into lo.
module muldiv_step #(
    parameter int XLEN = 32
) (
    input  logic                is_div_i,
    input  logic [2*XLEN-1:0]   prod_i,
    input  logic [XLEN-1:0]     opnd_i,
    output logic [2*XLEN-1:0]   prod_o
);

    logic [XLEN:0]   sum;
    logic [XLEN:0]   rem_sh;
    logic            rem_ge;
    logic [XLEN-1:0] rem_sub;

    always_comb begin
        sum     = {1'b0, prod_i[2*XLEN-1:XLEN]} + (prod_i[0] ? {1'b0, opnd_i} : '0);
        rem_sh  = prod_i[2*XLEN-1:XLEN-1];
        rem_ge  = (rem_sh >= {1'b0, opnd_i});
        // When the trial subtract succeeds the result is below the divisor, so XLEN bits suffice.
        rem_sub = rem_sh[XLEN-1:0] - opnd_i;
        if (is_div_i) begin
            if (rem_ge) begin
                prod_o = {rem_sub, prod_i[XLEN-2:0], 1'b1};
            end else begin
                prod_o = {rem_sh[XLEN-1:0], prod_i[XLEN-2:0], 1'b0};
            end
        end else begin
            prod_o = {sum, prod_i[XLEN-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_seq.sv
// Iterative RV32M multiply/divide unit: Done pulses 34 cycles after Start (2 for trivial cases with MULDIV_EARLY_OUT_EN).
// Start is ignored while Busy; Flush aborts any in-flight operation and leaves Result untouched.
module muldiv_seq
    import muldiv_seq_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int ITER = XLEN
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            Start,
    input  logic            Flush,
    input  logic [2:0]      MdOp,
    input  logic [XLEN-1:0] Operand1,
    input  logic [XLEN-1:0] Operand2,
    output logic            Busy,
    output logic            Done,
    output logic [XLEN-1:0] Result
);

    localparam int CW = $clog2(ITER) + 1;

    state_t            state_q;
    logic [CW-1:0]     cnt_q;
    logic [2:0]        op_q;
    logic [2*XLEN-1:0] prod_q;
    logic [2*XLEN-1:0] prod_d;
    logic [XLEN-1:0]   opnd_q;
    logic              neg_q;
    logic              neg_rem_q;
    logic              busy_q;
    logic              done_q;
    logic [XLEN-1:0]   result_q;

    logic              s1, s2, div_zero;
    logic [XLEN-1:0]   mag1, mag2;
    logic [2*XLEN-1:0] init_prod_d;
    logic [XLEN-1:0]   init_opnd_d;
    logic              init_neg_d;
    logic              go_fix_d;
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quo_fix, rem_fix, res_d;

    muldiv_step #(.XLEN(XLEN)) u_step (
        .is_div_i (op_is_div(op_q)),
        .prod_i   (prod_q),
        .opnd_i   (opnd_q),
        .prod_o   (prod_d)
    );

    // Operand conditioning at acceptance: magnitudes, sign flags, initial register image.
    always_comb begin
        s1          = op_signed1(MdOp) & Operand1[XLEN-1];
        s2          = op_signed2(MdOp) & Operand2[XLEN-1];
        mag1        = s1 ? -Operand1 : Operand1;
        mag2        = s2 ? -Operand2 : Operand2;
        div_zero    = (Operand2 == '0);
        init_neg_d  = op_is_div(MdOp) ? ((s1 ^ s2) & ~div_zero) : (s1 ^ s2);
        init_prod_d = op_is_div(MdOp) ? {{XLEN{1'b0}}, mag1} : {{XLEN{1'b0}}, mag2};
        init_opnd_d = op_is_div(MdOp) ? mag2 : mag1;
        go_fix_d    = 1'b0;
`ifdef MULDIV_EARLY_OUT_EN
        // Preload the exact image the full iteration would leave behind, so FIX is shared.
        if (op_is_div(MdOp)) begin
            if (div_zero) begin
                init_prod_d = {mag1, {XLEN{1'b1}}};
                go_fix_d    = 1'b1;
            end else if (op_signed2(MdOp) && (Operand1 == {1'b1, {(XLEN-1){1'b0}}})
                         && (Operand2 == {XLEN{1'b1}})) begin
                init_prod_d = {{XLEN{1'b0}}, 1'b1, {(XLEN-1){1'b0}}};
                go_fix_d    = 1'b1;
            end
        end else if ((Operand1 == '0) || (Operand2 == '0)) begin
            init_prod_d = '0;
            go_fix_d    = 1'b1;
        end
`endif
    end

    always_comb begin
        prod_fix = neg_q ? -prod_q : prod_q;
        quo_fix  = neg_q ? -prod_q[XLEN-1:0] : prod_q[XLEN-1:0];
        rem_fix  = neg_rem_q ? -prod_q[2*XLEN-1:XLEN] : prod_q[2*XLEN-1:XLEN];
        case (op_q)
            MD_MUL:                       res_d = prod_fix[XLEN-1:0];
            MD_MULH, MD_MULHSU, MD_MULHU: res_d = prod_fix[2*XLEN-1:XLEN];
            MD_DIV, MD_DIVU:              res_d = quo_fix;
            default:                      res_d = rem_fix;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            op_q      <= '0;
            prod_q    <= '0;
            opnd_q    <= '0;
            neg_q     <= 1'b0;
            neg_rem_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            result_q  <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    done_q <= 1'b0;
                    if (Start && !Flush) begin
                        op_q      <= MdOp;
                        prod_q    <= init_prod_d;
                        opnd_q    <= init_opnd_d;
                        neg_q     <= init_neg_d;
                        neg_rem_q <= s1;
                        cnt_q     <= '0;
                        busy_q    <= 1'b1;
                        state_q   <= go_fix_d ? ST_FIX : ST_CALC;
                    end
                end
                ST_CALC: begin
                    if (Flush) begin
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end else begin
                        prod_q <= prod_d;
                        cnt_q  <= cnt_q + 1'b1;
                        if (cnt_q == CW'(ITER - 1)) begin
                            state_q <= ST_FIX;
                        end
                    end
                end
                ST_FIX: begin
                    if (Flush) begin
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end else begin
                        result_q <= res_d;
                        done_q   <= 1'b1;
                        state_q  <= ST_DONE;
                    end
                end
                default: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign Busy   = busy_q;
    assign Done   = done_q;
    assign Result = result_q;

endmodule
